// File: rtl/hci_mem_bank_if.sv
// hci_mem request/response bundle between an initiator and one TCDM bank.
// master = initiator side, slave = bank side.
interface hci_mem_bank_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 8,
  parameter int unsigned IW = 8
);
  logic             req;
  logic             gnt;
  logic [AW-1:0]    add;
  logic             wen;
  logic [DW-1:0]    data;
  logic [DW/BW-1:0] be;
  logic [IW-1:0]    id;
  logic             ts_set;
  logic             r_valid;
  logic [DW-1:0]    r_data;
  logic [IW-1:0]    r_id;

  modport master (
    output req, add, wen, data, be, id, ts_set,
    input  gnt, r_valid, r_data, r_id
  );

  modport slave (
    input  req, add, wen, data, be, id, ts_set,
    output gnt, r_valid, r_data, r_id
  );
endinterface

// File: rtl/hci_mem_bank_responder.sv
// TCDM bank responder: byte-enabled SRAM, fixed-latency in-order responses,
// test-and-set. Optional grant stalls via HCI_MEM_BANK_RANDOM_STALL_EN.
module hci_mem_bank_responder #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned BW      = 8,
  parameter int unsigned IW      = 8,
  parameter int unsigned N_WORDS = 1024,
  parameter int unsigned LATENCY = 1
) (
  input logic           clk_i,
  input logic           rst_ni,
  hci_mem_bank_if.slave bus
);
  localparam int unsigned OFF = $clog2(DW/8);
  localparam int unsigned IXW = $clog2(N_WORDS);
  localparam int unsigned NBE = DW/BW;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TS_WR = 1'b1;

  if (LATENCY < 1 || LATENCY > 4) begin : g_lat_chk
    $error("hci_mem_bank_responder: LATENCY must be 1..4");
  end

  logic [0:0]     state_q;
  logic [IXW-1:0] idx;
  logic [IXW-1:0] ts_idx_q;
  logic [DW-1:0]  mem_q [N_WORDS];
  logic           stall;
  logic           gnt;
  logic           acc;
  logic [DW-1:0]  rdata;
  logic           unused_add;

  logic [LATENCY-1:0] v_q;
  logic [IW-1:0]      id_q [LATENCY];
  logic [DW-1:0]      d_q  [LATENCY];

  assign idx        = bus.add[OFF +: IXW];
  assign unused_add = ^bus.add;

`ifdef HCI_MEM_BANK_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0],
                 lfsr_q[15] ^ lfsr_q[13] ^
                 lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign gnt     = rst_ni & (state_q == IDLE) & ~stall;
  assign acc     = bus.req & gnt;
  assign rdata   = bus.wen ? mem_q[idx] : '0;
  assign bus.gnt = gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ts_idx_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc & bus.wen & bus.ts_set) begin
            state_q  <= TS_WR;
            ts_idx_q <= idx;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset forces IDLE asynchronously, so an interrupted TS write never lands.
  always_ff @(posedge clk_i) begin
    unique case (1'b1)
      state_q == TS_WR: mem_q[ts_idx_q] <= '1;
      acc && !bus.wen: begin
        for (int k = 0; k < NBE; k++) begin
          if (bus.be[k]) begin
            mem_q[idx][k*BW +: BW] <= bus.data[k*BW +: BW];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        id_q[i] <= '0;
        d_q[i]  <= '0;
      end
    end else begin
      v_q[0]  <= acc;
      id_q[0] <= acc ? bus.id : '0;
      d_q[0]  <= acc ? rdata : '0;
      for (int i = 1; i < LATENCY; i++) begin
        v_q[i]  <= v_q[i-1];
        id_q[i] <= id_q[i-1];
        d_q[i]  <= d_q[i-1];
      end
    end
  end

  assign bus.r_valid = v_q[LATENCY-1];
  assign bus.r_id    = id_q[LATENCY-1];
  assign bus.r_data  = d_q[LATENCY-1];
endmodule
